// File: rtl/bcd_to_binary_seq.sv
// Digit-serial packed-BCD to unsigned binary converter, MSD first, one digit per cycle.
// Optional invalid-digit detection is enabled by defining BCD_TO_BIN_DIGIT_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [BIN_W-1:0]        out_bin,
  output logic                    out_err,
  output logic [1:0]              dbg_state
);

  localparam int SR_W  = 4 * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  // Handshakes: a transfer happens at a rising edge where val and rdy are both 1.
  // The producer holds data steady while val=1 and rdy=0; val never waits on rdy.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SR_W-1:0]  r_sr;
  logic [BIN_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_top;
  logic [BIN_W-1:0] w_acc_next;
  logic             w_accept;
  logic             w_last;

  assign w_top      = r_sr[SR_W-1 -: 4];
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_top);
  assign w_accept   = in_val && (r_state == IDLE);
  assign w_last     = (r_cnt == CNT_LAST);
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    case (r_state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) w_next = CONV;
      end
      CONV: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sr  <= in_bcd;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV) begin
      r_sr  <= r_sr << 4;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  // Sticky over the whole conversion; a fresh accept starts clean.
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == CONV) && (w_top > 4'd9)) begin
      r_err <= 1'b1;
    end
  end

  assign out_err = (r_state == DONE) && r_err;
  assign out_bin = ((r_state == DONE) && !r_err) ? r_acc : '0;
`else
  assign out_err = 1'b0;
  assign out_bin = (r_state == DONE) ? r_acc : '0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: default 2-digit instance plus a 3-digit
// instance for latency and back-to-back throughput.
module tb_bcd_to_binary_seq;

  logic clk;
  logic rst_n;

  // default instance: 2 digits, 7 bits
  logic       in_val, in_rdy, out_val, out_rdy, out_err;
  logic [7:0] in_bcd;
  logic [6:0] out_bin;
  logic [1:0] dbg_state;

  // 3-digit instance: 3 digits, 10 bits
  logic        in_val_b, in_rdy_b, out_val_b, out_rdy_b, out_err_b;
  logic [11:0] in_bcd_b;
  logic [9:0]  out_bin_b;
  logic [1:0]  dbg_state_b;

  int n_vec;
  int n_err;
  int cyc;
  logic [9:0] exp_q[$];
  int acc_cyc[$];

  bcd_to_binary_seq #(.NUM_DIGITS(2), .BIN_W(7)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_bcd(in_bcd),
    .out_val(out_val), .out_rdy(out_rdy), .out_bin(out_bin), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  bcd_to_binary_seq #(.NUM_DIGITS(3), .BIN_W(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_val(in_val_b), .in_rdy(in_rdy_b), .in_bcd(in_bcd_b),
    .out_val(out_val_b), .out_rdy(out_rdy_b), .out_bin(out_bin_b), .out_err(out_err_b),
    .dbg_state(dbg_state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard for the 3-digit instance
  always @(posedge clk) begin
    if (rst_n && out_val_b && out_rdy_b) begin
      if (exp_q.size() == 0) begin
        chk("b_unexpected_out", 32'(out_bin_b), 32'hFFFF_FFFF);
      end else begin
        chk("b_out_bin", 32'(out_bin_b), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && in_val_b && in_rdy_b) acc_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full transaction on the default instance, optional backpressure hold
  task automatic run_a(input string tag, input logic [7:0] bcd, input logic [6:0] exp_bin,
                       input logic exp_err, input int hold);
    int n;
    n = 0;
    while (!in_rdy && n < 20) begin tick(); n++; end
    chk({tag, ".in_rdy"}, 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in_bcd = bcd;
    tick();
    in_val = 1'b0;
    in_bcd = 8'hFF;
    chk({tag, ".busy"}, 32'(in_rdy), 32'd0);
    n = 0;
    while (!out_val && n < 20) begin tick(); n++; end
    chk({tag, ".latency"}, 32'(n), 32'd2);
    chk({tag, ".bin"}, 32'(out_bin), 32'(exp_bin));
    chk({tag, ".err"}, 32'(out_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_val"}, 32'(out_val), 32'd1);
      chk({tag, ".hold_bin"}, 32'(out_bin), 32'(exp_bin));
      chk({tag, ".hold_rdy"}, 32'(in_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk({tag, ".val_drop"}, 32'(out_val), 32'd0);
    chk({tag, ".rdy_back"}, 32'(in_rdy), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;
    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    in_val = 1'b0; in_bcd = 8'h00; out_rdy = 1'b0;
    in_val_b = 1'b0; in_bcd_b = 12'h000; out_rdy_b = 1'b0;
    repeat (3) tick();

    chk("rst.in_rdy", 32'(in_rdy), 32'd1);
    chk("rst.out_val", 32'(out_val), 32'd0);
    chk("rst.out_bin", 32'(out_bin), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    run_a("h42", 8'h42, 7'd42, 1'b0, 0);
    run_a("h99", 8'h99, 7'd99, 1'b0, 0);
    run_a("h00", 8'h00, 7'd0, 1'b0, 0);
    run_a("h31", 8'h31, 7'd31, 1'b0, 0);
    run_a("bp", 8'h68, 7'd68, 1'b0, 5);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    run_a("h1A", 8'h1A, 7'd0, 1'b1, 0);
    run_a("after_err", 8'h07, 7'd7, 1'b0, 0);
`else
    run_a("h1A", 8'h1A, 7'd20, 1'b0, 0);
    run_a("hF0", 8'hF0, 7'd22, 1'b0, 0);
`endif

    // reset one cycle after accepting 0x57
    in_val = 1'b1; in_bcd = 8'h57;
    tick();
    in_val = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid.in_rdy", 32'(in_rdy), 32'd1);
    chk("rstmid.out_bin", 32'(out_bin), 32'd0);
    chk("rstmid.state", 32'(dbg_state), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_val) seen = 1'b1;
      tick();
    end
    chk("rstmid.no_out", 32'(seen), 32'd0);

    // 3-digit instance: single conversion latency
    in_val_b = 1'b1; in_bcd_b = 12'h999;
    exp_q.push_back(10'd999);
    tick();
    in_val_b = 1'b0;
    n = 0;
    while (!out_val_b && n < 20) begin tick(); n++; end
    chk("b999.latency", 32'(n), 32'd3);
    chk("b999.err", 32'(out_err_b), 32'd0);
    out_rdy_b = 1'b1;
    tick();
    out_rdy_b = 1'b0;
    acc_cyc.delete();

    // back-to-back: in_val and out_rdy held high
    out_rdy_b = 1'b1;
    in_val_b = 1'b1;
    in_bcd_b = 12'h123; exp_q.push_back(10'd123);
    tick();
    n = 0;
    while (!in_rdy_b && n < 20) begin tick(); n++; end
    in_bcd_b = 12'h500; exp_q.push_back(10'd500);
    tick();
    n = 0;
    while (!in_rdy_b && n < 20) begin tick(); n++; end
    in_bcd_b = 12'h007; exp_q.push_back(10'd7);
    tick();
    in_val_b = 1'b0;
    repeat (10) tick();
    out_rdy_b = 1'b0;

    chk("b2b.accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b.gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      chk("b2b.gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    end
    chk("b2b.q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
